// File: rtl/div_seq_pkg.sv
// Shared types, widths and encodings for the EX-stage divide sequencer.
package div_seq_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned RES_W  = 2 * DATA_W;
    localparam int unsigned WORK_W = 2 * DATA_W + 1;
    localparam int unsigned CNT_W  = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_ZERO = 2'b01,
        DIV_ON   = 2'b10,
        DIV_END  = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    // Two's complement negate.
    function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v);
        return ~v + DATA_W'(1);
    endfunction

    // Magnitude of v when treated as signed, otherwise v unchanged.
    function automatic logic [DATA_W-1:0] abs_if(input logic en, input logic [DATA_W-1:0] v);
        return (en && v[DATA_W-1]) ? neg_w(v) : v;
    endfunction

endpackage

// File: rtl/div_seq_if.sv
// EX <-> divider request/result bundle.
import div_seq_pkg::*;

interface div_seq_if;
    logic              signed_div_i;
    logic [DATA_W-1:0] opdata1_i;
    logic [DATA_W-1:0] opdata2_i;
    logic              start_i;
    logic              annul_i;
    logic [RES_W-1:0]  result_o;
    logic              ready_o;
    logic              stallreq_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, stallreq_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, stallreq_o
    );
endinterface

// File: rtl/div_step.sv
// One radix-2 restoring division iteration on the 65-bit work word.
import div_seq_pkg::*;

module div_step (
    input  logic [WORK_W-1:0] i_work,
    input  logic [DATA_W-1:0] i_divisor,
    output logic [WORK_W-1:0] o_work
);

    logic [DATA_W:0] w_diff;

    // Trial subtract; the partial remainder includes work[64] so divisors with the MSB set compare correctly.
    always_comb begin
        w_diff = i_work[WORK_W-1:DATA_W] - {1'b0, i_divisor};
        if (w_diff[DATA_W]) begin
            o_work = {i_work[WORK_W-2:0], 1'b0};
        end else begin
            o_work = {w_diff[DATA_W-1:0], i_work[DATA_W-1:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU sequencer: 32 restoring steps, EX stall while busy, {rem, quot} result.
import div_seq_pkg::*;

module div_seq (
    input  logic       clk,
    input  logic       rst,
    div_seq_if.slave   bus
);

    div_state_e        r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [WORK_W-1:0] r_work, w_work_nxt, w_step;
    logic [DATA_W-1:0] r_divisor, w_divisor_nxt;
    logic              r_signed, w_signed_nxt;
    logic              r_sign1, w_sign1_nxt;
    logic              r_sign2, w_sign2_nxt;
    logic [RES_W-1:0]  r_result, w_result_nxt;
    logic              r_ready, w_ready_nxt;
    logic              w_stall;
    logic [DATA_W-1:0] w_quot, w_rem;
    logic              w_abort;

    div_step u_step (
        .i_work    (r_work),
        .i_divisor (r_divisor),
        .o_work    (w_step)
    );

    // Sign fix-up of the final step: quotient follows sign XOR, remainder follows the dividend.
    always_comb begin
        w_quot = w_step[DATA_W-1:0];
        w_rem  = w_step[WORK_W-1:DATA_W+1];
        if (r_signed && (r_sign1 ^ r_sign2)) w_quot = neg_w(w_quot);
        if (r_signed && r_sign1)             w_rem  = neg_w(w_rem);
    end

    assign w_abort = bus.annul_i || (bus.start_i == DivStop);

    // Next-state, datapath and output decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_work_nxt    = r_work;
        w_divisor_nxt = r_divisor;
        w_signed_nxt  = r_signed;
        w_sign1_nxt   = r_sign1;
        w_sign2_nxt   = r_sign2;
        w_result_nxt  = r_result;
        w_ready_nxt   = r_ready;
        w_stall       = 1'b0;
        case (r_state)
            DIV_IDLE: begin
                if (bus.start_i == DivStart && !bus.annul_i) begin
                    w_stall = 1'b1;
                    if (bus.opdata2_i == '0) begin
                        w_state_nxt = DIV_ZERO;
                    end else begin
                        w_state_nxt   = DIV_ON;
                        w_work_nxt    = {{DATA_W{1'b0}}, abs_if(bus.signed_div_i, bus.opdata1_i), 1'b0};
                        w_divisor_nxt = abs_if(bus.signed_div_i, bus.opdata2_i);
                        w_signed_nxt  = bus.signed_div_i;
                        w_sign1_nxt   = bus.opdata1_i[DATA_W-1];
                        w_sign2_nxt   = bus.opdata2_i[DATA_W-1];
                        w_cnt_nxt     = '0;
                    end
                end
            end
            DIV_ZERO: begin
                w_stall = 1'b1;
                if (w_abort) begin
                    w_state_nxt = DIV_IDLE;
                end else begin
                    w_state_nxt  = DIV_END;
                    w_result_nxt = '0;
                    w_ready_nxt  = DivResultReady;
                end
            end
            DIV_ON: begin
                w_stall = 1'b1;
                if (w_abort) begin
                    w_state_nxt = DIV_IDLE;
                end else begin
                    w_work_nxt = w_step;
                    w_cnt_nxt  = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(DATA_W - 1)) begin
                        w_state_nxt  = DIV_END;
                        w_result_nxt = {w_rem, w_quot};
                        w_ready_nxt  = DivResultReady;
                    end
                end
            end
            DIV_END: begin
                if (bus.start_i == DivStop) begin
                    w_state_nxt  = DIV_IDLE;
                    w_result_nxt = '0;
                    w_ready_nxt  = DivResultNotReady;
                end
            end
            default: w_state_nxt = DIV_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any work in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= DIV_IDLE;
            r_cnt     <= '0;
            r_work    <= '0;
            r_divisor <= '0;
            r_signed  <= 1'b0;
            r_sign1   <= 1'b0;
            r_sign2   <= 1'b0;
            r_result  <= '0;
            r_ready   <= DivResultNotReady;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_work    <= w_work_nxt;
            r_divisor <= w_divisor_nxt;
            r_signed  <= w_signed_nxt;
            r_sign1   <= w_sign1_nxt;
            r_sign2   <= w_sign2_nxt;
            r_result  <= w_result_nxt;
            r_ready   <= w_ready_nxt;
        end
    end

    assign bus.result_o   = r_result;
    assign bus.ready_o    = r_ready;
    assign bus.stallreq_o = w_stall;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq against an arithmetic reference model.
import div_seq_pkg::*;

module tb_div_seq;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    div_seq_if bus ();

    div_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference: magnitude divide, then quotient sign = XOR, remainder sign = dividend; /0 gives 0.
    function automatic logic [63:0] ref_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned ma, mb, q, r;
        logic sg;
        sg = (op == EXE_DIV_OP);
        if (b == 32'd0) return 64'd0;
        ma = (sg && a[31]) ? (64'h1_0000_0000 - {32'd0, a}) : {32'd0, a};
        mb = (sg && b[31]) ? (64'h1_0000_0000 - {32'd0, b}) : {32'd0, b};
        q = ma / mb;
        r = ma % mb;
        if (sg && (a[31] ^ b[31])) q = -q;
        if (sg && a[31])           r = -r;
        return {r[31:0], q[31:0]};
    endfunction

    // Issue one request, hold start until ready, then drop start; reports latency and stall cycles.
    task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [63:0] res, output int lat, output int stalls,
                           output logic stall_at_rdy);
        @(negedge clk);
        bus.signed_div_i = (op == EXE_DIV_OP);
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.annul_i      = 1'b0;
        bus.start_i      = 1'b1;
        #1;
        lat    = 0;
        stalls = 0;
        while (bus.ready_o !== 1'b1 && lat < 100) begin
            if (bus.stallreq_o === 1'b1) stalls++;
            @(negedge clk);
            lat++;
        end
        res          = bus.result_o;
        stall_at_rdy = bus.stallreq_o;
        bus.start_i  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i = '0;
        bus.opdata2_i = '0;
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (bus.ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b expected 0", bus.ready_o); end
        n_vec++; if (bus.result_o !== 64'd0) begin n_err++; $display("FAIL reset_result: got %h expected 0", bus.result_o); end
        n_vec++; if (bus.stallreq_o !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b expected 0", bus.stallreq_o); end
        rst = 1'b0;
    endtask

    task automatic test_unsigned_basic();
        logic [63:0] res; int lat, st; logic sr;
        run_div(EXE_DIVU_OP, 32'd100, 32'd7, res, lat, st, sr);
        n_vec++; if (lat != 33) begin n_err++; $display("FAIL u100_7_latency: got %0d expected 33", lat); end
        n_vec++; if (st != 33) begin n_err++; $display("FAIL u100_7_stall_cycles: got %0d expected 33", st); end
        n_vec++; if (sr !== 1'b0) begin n_err++; $display("FAIL u100_7_stall_at_ready: got %b expected 0", sr); end
        n_vec++; if (res !== {32'd2, 32'd14}) begin n_err++; $display("FAIL u100_7_result: got %h expected %h", res, {32'd2, 32'd14}); end
        @(negedge clk);
        n_vec++; if (bus.ready_o !== 1'b0) begin n_err++; $display("FAIL release_ready: got %b expected 0", bus.ready_o); end
        n_vec++; if (bus.result_o !== 64'd0) begin n_err++; $display("FAIL release_result: got %h expected 0", bus.result_o); end
    endtask

    task automatic test_sign_modes();
        logic [63:0] res; int lat, st; logic sr;
        run_div(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, res, lat, st, sr);
        n_vec++; if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin n_err++; $display("FAIL s_m7_2: got %h expected %h", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD}); end
        run_div(EXE_DIVU_OP, 32'hFFFF_FFF9, 32'd2, res, lat, st, sr);
        n_vec++; if (res !== {32'd1, 32'h7FFF_FFFC}) begin n_err++; $display("FAIL u_fff9_2: got %h expected %h", res, {32'd1, 32'h7FFF_FFFC}); end
    endtask

    task automatic test_div_zero();
        logic [63:0] res; int lat, st; logic sr;
        run_div(EXE_DIVU_OP, 32'h1234, 32'd0, res, lat, st, sr);
        n_vec++; if (lat != 2) begin n_err++; $display("FAIL div0_latency: got %0d expected 2", lat); end
        n_vec++; if (st != 2) begin n_err++; $display("FAIL div0_stall_cycles: got %0d expected 2", st); end
        n_vec++; if (res !== 64'd0) begin n_err++; $display("FAIL div0_result: got %h expected 0", res); end
        n_vec++; if (sr !== 1'b0) begin n_err++; $display("FAIL div0_stall_at_ready: got %b expected 0", sr); end
    endtask

    task automatic test_annul();
        logic [63:0] res; int lat, st; logic sr; int seen;
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i = 32'd1000;
        bus.opdata2_i = 32'd3;
        bus.start_i = 1'b1;
        bus.annul_i = 1'b0;
        repeat (11) @(negedge clk);
        n_vec++; if (bus.stallreq_o !== 1'b1) begin n_err++; $display("FAIL annul_busy_stall: got %b expected 1", bus.stallreq_o); end
        bus.annul_i = 1'b1;
        @(negedge clk);
        n_vec++; if (bus.stallreq_o !== 1'b0) begin n_err++; $display("FAIL annul_stall: got %b expected 0", bus.stallreq_o); end
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.ready_o === 1'b1) seen++;
        end
        n_vec++; if (seen != 0) begin n_err++; $display("FAIL annul_ready_seen: got %0d expected 0", seen); end
        run_div(EXE_DIVU_OP, 32'd9, 32'd3, res, lat, st, sr);
        n_vec++; if (res !== {32'd0, 32'd3}) begin n_err++; $display("FAIL after_annul_9_3: got %h expected %h", res, {32'd0, 32'd3}); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] res; int lat, st; logic sr;
        @(negedge clk);
        bus.signed_div_i = 1'b1;
        bus.opdata1_i = 32'h0765_4321;
        bus.opdata2_i = 32'd5;
        bus.start_i = 1'b1;
        repeat (21) @(negedge clk);
        rst = 1'b1;
        bus.start_i = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.ready_o !== 1'b0) begin n_err++; $display("FAIL rstmid_ready: got %b expected 0", bus.ready_o); end
        n_vec++; if (bus.result_o !== 64'd0) begin n_err++; $display("FAIL rstmid_result: got %h expected 0", bus.result_o); end
        n_vec++; if (bus.stallreq_o !== 1'b0) begin n_err++; $display("FAIL rstmid_stall: got %b expected 0", bus.stallreq_o); end
        rst = 1'b0;
        run_div(EXE_DIVU_OP, 32'hFFFF_FFFF, 32'd1, res, lat, st, sr);
        n_vec++; if (lat != 33) begin n_err++; $display("FAIL after_rst_latency: got %0d expected 33", lat); end
        n_vec++; if (res !== {32'd0, 32'hFFFF_FFFF}) begin n_err++; $display("FAIL after_rst_ffff_1: got %h expected %h", res, {32'd0, 32'hFFFF_FFFF}); end
    endtask

    task automatic test_overflow_hold();
        logic [63:0] res; int lat, st; logic sr;
        logic [63:0] exp_res;
        exp_res = {32'd0, 32'h8000_0000};
        run_div(EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, st, sr);
        n_vec++; if (res !== exp_res) begin n_err++; $display("FAIL ovf_result: got %h expected %h", res, exp_res); end
        bus.start_i = 1'b1;
        bus.annul_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.opdata1_i = $urandom;
            bus.opdata2_i = $urandom;
            @(negedge clk);
            n_vec++; if (bus.ready_o !== 1'b1) begin n_err++; $display("FAIL hold_ready[%0d]: got %b expected 1", i, bus.ready_o); end
            n_vec++; if (bus.result_o !== exp_res) begin n_err++; $display("FAIL hold_result[%0d]: got %h expected %h", i, bus.result_o, exp_res); end
            n_vec++; if (bus.stallreq_o !== 1'b0) begin n_err++; $display("FAIL hold_stall[%0d]: got %b expected 0", i, bus.stallreq_o); end
        end
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.ready_o !== 1'b0) begin n_err++; $display("FAIL hold_release_ready: got %b expected 0", bus.ready_o); end
        n_vec++; if (bus.result_o !== 64'd0) begin n_err++; $display("FAIL hold_release_result: got %h expected 0", bus.result_o); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] res; int lat, st; logic sr;
        logic [7:0] op; logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = ($urandom_range(0, 1) == 0) ? EXE_DIV_OP : EXE_DIVU_OP;
            a  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'h8000_0000 | $urandom;
                3, 4:    b = $urandom_range(1, 255);
                default: b = $urandom;
            endcase
            if (i == 0) a = 32'h8000_0000;
            run_div(op, a, b, res, lat, st, sr);
            n_vec++; if (res !== ref_div(op, a, b)) begin n_err++; $display("FAIL rand_result[%0d] op=%h a=%h b=%h: got %h expected %h", i, op, a, b, res, ref_div(op, a, b)); end
            n_vec++; if (lat != ((b == 32'd0) ? 2 : 33)) begin n_err++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, (b == 32'd0) ? 2 : 33); end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_basic();
        test_sign_modes();
        test_div_zero();
        test_annul();
        test_reset_mid();
        test_overflow_hold();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
